// File: rtl/ffd_pkg.sv
// Shared constants for the ffd enable-register family: default width and
// default reset value used by ffd4_en_reg and its cells.
package ffd_pkg;

  localparam int FFD_MAX_WIDTH     = 32;
  localparam int FFD_DEFAULT_WIDTH = 4;

  // Wide enough for any legal WIDTH; the top slices off what it needs.
  localparam logic [FFD_MAX_WIDTH-1:0] FFD_DEFAULT_RESET_VALUE = '0;

endpackage

// File: rtl/ffd4_en_reg_cell.sv
// ffd1_en_cell: 1-bit D flip-flop with synchronous active-high reset and
// load enable. Reset wins over enable; otherwise the bit holds.
module ffd1_en_cell #(
  parameter logic RESET_VALUE = 1'b0
) (
  input  logic clk,
  input  logic rst,
  input  logic enable,
  input  logic d,
  output logic q
);

  logic r_q;

  // NOTE: non-blocking (<=) so every flop samples pre-edge values; blocking
  // here would create order-dependent races between cells.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_q <= RESET_VALUE;
    end else if (enable) begin
      r_q <= d;
    end
  end

  assign q = r_q;

endmodule

// File: rtl/ffd4_en_reg.sv
// ffd4_en_reg: WIDTH-bit holding register built from ffd1_en_cell bits.
// Define FFD4_EN_REG_PARITY_EN to add a registered even-parity output q_parity.
module ffd4_en_reg
  import ffd_pkg::*;
#(
  parameter int               WIDTH       = FFD_DEFAULT_WIDTH,
  parameter logic [WIDTH-1:0] RESET_VALUE = FFD_DEFAULT_RESET_VALUE[WIDTH-1:0]
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             enable,
  input  logic [WIDTH-1:0] d,
  output logic [WIDTH-1:0] q
`ifdef FFD4_EN_REG_PARITY_EN
  ,
  output logic             q_parity
`endif
);

  logic [WIDTH-1:0] w_q;

  for (genvar i = 0; i < WIDTH; i++) begin : g_cell
    ffd1_en_cell #(
      .RESET_VALUE (RESET_VALUE[i])
    ) u_cell (
      .clk    (clk),
      .rst    (rst),
      .enable (enable),
      .d      (d[i]),
      .q      (w_q[i])
    );
  end

  assign q = w_q;

`ifdef FFD4_EN_REG_PARITY_EN
  logic r_parity;

  // Parity of the incoming d, so it lands on the same edge as q itself.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_parity <= ^RESET_VALUE;
    end else if (enable) begin
      r_parity <= ^d;
    end
  end

  assign q_parity = r_parity;
`endif

endmodule

// File: tb/tb_ffd4_en_reg.sv
// Self-checking bench for ffd4_en_reg: directed cases for reset, hold, load,
// reset priority and short reset glitches, then randomized traffic vs a model.
module tb_ffd4_en_reg;

  localparam int W = 4;

  logic         clk;
  logic         rst;
  logic         enable;
  logic [W-1:0] d;
  logic [W-1:0] q;
`ifdef FFD4_EN_REG_PARITY_EN
  logic         q_parity;
`endif

  int n_checks = 0;
  int n_pass   = 0;

  logic [W-1:0] model_q;

  ffd4_en_reg #(
    .WIDTH (W)
  ) dut (
    .clk      (clk),
    .rst      (rst),
    .enable   (enable),
    .d        (d),
    .q        (q)
`ifdef FFD4_EN_REG_PARITY_EN
    ,
    .q_parity (q_parity)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      $display("FAIL %s: got %h expected %h (t=%0t)", tag, got, exp, $time);
    end else begin
      n_pass++;
    end
  endtask

  // Model: the value a holding register should show after a rising edge.
  function automatic logic [W-1:0] next_value(input logic [W-1:0] cur, input logic r,
                                              input logic e, input logic [W-1:0] dv);
    if (r)      return '0;
    else if (e) return dv;
    else        return cur;
  endfunction

  function automatic logic even_parity(input logic [W-1:0] v);
    int ones = 0;
    for (int i = 0; i < W; i++) ones += int'(v[i]);
    return logic'(ones % 2);
  endfunction

  // Drive inputs mid-cycle, optionally wiggle d first, then sample after the edge.
  task automatic step(input logic r, input logic e, input logic [W-1:0] dv, input bit wiggle);
    @(negedge clk);
    rst    = r;
    enable = e;
    d      = wiggle ? W'($urandom) : dv;
    if (wiggle) begin
      #2;
      d = dv;
    end
    @(posedge clk);
    #1;
    model_q = next_value(model_q, r, e, dv);
  endtask

  task automatic check_q(input string tag, input logic [W-1:0] exp);
    check(tag, 32'(q), 32'(exp));
`ifdef FFD4_EN_REG_PARITY_EN
    check({tag, "_par"}, 32'(q_parity), 32'(even_parity(exp)));
`endif
  endtask

  initial begin
    rst     = 1'b0;
    enable  = 1'b0;
    d       = '0;
    model_q = 'x;

    // Reset
    step(1'b1, 1'b0, 4'b0000, 1'b0);
    check_q("reset", 4'b0000);

    // Hold when disabled
    for (int i = 0; i < 3; i++) begin
      step(1'b0, 1'b0, 4'b1001, 1'b0);
      check_q("hold_dis", 4'b0000);
    end
    step(1'b0, 1'b0, 4'b0000, 1'b0);
    check_q("hold_dis_d0", 4'b0000);

    // Enabled load, then follow to zero
    step(1'b0, 1'b1, 4'b0101, 1'b0);
    check_q("load_0101", 4'b0101);
    step(1'b0, 1'b1, 4'b0000, 1'b0);
    check_q("load_0000", 4'b0000);

    // Disable after load
    step(1'b0, 1'b1, 4'b0111, 1'b0);
    check_q("load_0111", 4'b0111);
    for (int i = 0; i < 3; i++) begin
      step(1'b0, 1'b0, 4'b0000, 1'b0);
      check_q("keep_0111", 4'b0111);
    end

    // Reset priority over enabled load
    step(1'b0, 1'b1, 4'b1111, 1'b0);
    check_q("load_1111", 4'b1111);
    step(1'b1, 1'b1, 4'b0000, 1'b0);
    check_q("rst_over_en", 4'b0000);
    step(1'b0, 1'b1, 4'b1010, 1'b0);
    check_q("load_after_rst", 4'b1010);

    // Short rst glitch that never spans a rising edge
    step(1'b0, 1'b1, 4'b0110, 1'b0);
    check_q("load_0110", 4'b0110);
    @(negedge clk);
    enable = 1'b0;
    d      = 4'b0000;
    #2 rst = 1'b1;
    #1 rst = 1'b0;
    #1;
    check_q("glitch_mid", 4'b0110);
    @(posedge clk);
    #1;
    check_q("glitch_edge", 4'b0110);

    // Only the value present at the edge is captured
    step(1'b0, 1'b1, 4'b1100, 1'b1);
    check_q("last_d_wins", 4'b1100);

    // Randomized traffic against the model
    for (int i = 0; i < 300; i++) begin
      logic         r;
      logic         e;
      logic [W-1:0] dv;
      r  = ($urandom_range(0, 15) == 0);
      e  = 1'($urandom_range(0, 1));
      dv = W'($urandom);
      step(r, e, dv, bit'($urandom_range(0, 1)));
      check_q("rand", model_q);
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
